keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 matrix keypad and turns raw column readings into debounced, single-key press events for the game controller. Drives `keyboard_row` one row at a time and samples `keyboard_col`. Emits one `key_valid` pulse with a 4-bit `key_code` per accepted press, and tracks release. Sits between the keypad pins and `gomoku_main`, replacing the loose `kb_scan_clk` row strobing with a self-timed, single-clock scanner.

## Interface
- `SCAN_DIV`, 10000: `clk` cycles each row is driven before sampling (10 ms at 1 MHz); legal range ≥ 2.
- `DEBOUNCE_FRAMES`, 3: consecutive identical frame results needed to accept a state change; legal range 1..15.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `keyboard_row` output 4: row drive, active-low, exactly one bit low at all times.
- `keyboard_col` input 4: column sense, active-low (pulled high externally), asynchronous to `clk`.
- `key_code` output 4: code of last accepted key, `row*4 + col`; held until next accepted press.
- `key_valid` output 1: one-cycle pulse when a new press is accepted.
- `key_down` output 1: high while the accepted key is still held.
- `key_multi` output 1: high while the debounced state is two or more keys pressed.

## Operation
- `keyboard_col` passes through a 2-flop synchronizer before use.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. Terminal count = "tick".
- On a tick, the synchronized columns are sampled for the current row. Sampled bits are written into a 16-bit frame snapshot: bit `row*4+col` = 1 when the column reads 0. `row_idx` then advances 0→1→2→3→0 and `keyboard_row` = ~(1 << row_idx).
- A frame ends on the tick with `row_idx`==3. Frame result is classified as:
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set, k = its index.
  - MULTI: ≥2 bits set.
- Debounce: compare the frame result with the previous frame result.
  - Equal: `stable_cnt` increments, saturating at DEBOUNCE_FRAMES.
  - Different: `stable_cnt` := 1.
  - The result is accepted when `stable_cnt` reaches DEBOUNCE_FRAMES. The accepted state is updated only then.
- FSM states are IDLE and DOWN.
  - IDLE, accepted SINGLE(k): `key_code`:=k, `key_valid` pulses, `key_down`:=1, go to DOWN.
  - IDLE, accepted MULTI or NONE: no event; stay in IDLE.
  - DOWN, accepted NONE: `key_down`:=0, go to IDLE.
  - DOWN, accepted SINGLE(other key) or MULTI: no event; stay in DOWN. A release is always required before the next press event.
- `key_multi` = 1 exactly when the accepted state is MULTI, in either FSM state.
- Snapshot bits are overwritten row by row. No stale bits survive into the next frame.

## Timing
- Reset values: `keyboard_row`=4'b1110, `key_code`=0, `key_valid`=0, `key_down`=0, `key_multi`=0. Also: dwell counter 0, `row_idx` 0, previous result NONE, accepted state NONE, `stable_cnt` 0, FSM IDLE, synchronizer flops 1.
- One frame = 4*SCAN_DIV cycles.
- A press stable across whole frames is accepted at the end of its DEBOUNCE_FRAMES-th full frame.
- `key_valid` rises the cycle after that frame-end tick, lasts exactly 1 cycle, and is never asserted on two consecutive cycles.
- `key_code` and `key_down` change in the same cycle `key_valid` rises.
- Release: `key_down` falls the cycle after the DEBOUNCE_FRAMES-th consecutive NONE frame ends.
- Partial-frame presses: a press appearing mid-frame can produce a first frame of SINGLE or NONE. Latency is therefore DEBOUNCE_FRAMES or DEBOUNCE_FRAMES+1 frames plus 3 cycles (synchronizer + output register).
- A bounce that changes any frame result restarts the count at 1.
- Reset asserted mid-operation: every register takes its reset value on the next edge. A key still held after reset is re-debounced from scratch and yields a fresh `key_valid`.
- With DEBOUNCE_FRAMES=1, every frame result is accepted immediately.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3, so one frame is 16 cycles. The keypad model drives `keyboard_col` from the current `keyboard_row`.
- Reset check: hold `rst` 3 cycles → all outputs at reset values, `keyboard_row`=1110. After release, the row pattern walks 1110→1101→1011→0111 every 4 cycles.
- Single press: hold row 2 / col 1 from reset release → exactly one `key_valid` pulse, `key_code`=9, `key_down`=1 within 3–4 frames. Releasing → `key_down`=0 after 3 NONE frames, with no further pulse.
- Bounce: toggle key 5 every 20 cycles for 100 cycles, then hold → no pulse during toggling; one pulse with `key_code`=5 after 3 stable frames.
- Multi-key: hold keys 0 and 15 together → `key_multi`=1 and no `key_valid`. Releasing key 15 leaves SINGLE(0) → pulse with `key_code`=0.
- Roll-over: press 3, then switch to 7 without a NONE gap → one pulse (3) only. Full release, then press 7 → second pulse with `key_code`=7.
- Reset mid-press: assert `rst` while key 12 is held in DOWN → outputs clear next cycle. After release of `rst`, with the key still held, a new pulse with `key_code`=12 arrives after debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column synchronizer, frame-level
// debounce and a single-key press/release state machine.
module keypad_scanner #(
    parameter int SCAN_DIV        = 10000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] keyboard_row,
    input  logic [3:0] keyboard_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_multi
);

    localparam int              CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX    = 4'(DEBOUNCE_FRAMES);

    localparam logic [1:0]      RES_NONE   = 2'd0;
    localparam logic [1:0]      RES_SINGLE = 2'd1;
    localparam logic [1:0]      RES_MULTI  = 2'd2;

    localparam logic [0:0]      S_IDLE     = 1'b0;
    localparam logic [0:0]      S_DOWN     = 1'b1;

    logic [3:0]    r_col_meta;
    logic [3:0]    r_col_sync;
    logic [CW-1:0] r_dwell;
    logic [1:0]    r_row_idx;
    logic [11:0]   r_snap;
    logic [5:0]    r_prev_res;
    logic [5:0]    r_acc_res;
    logic [3:0]    r_stable_cnt;
    logic [0:0]    r_state;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_down;

    logic          w_tick;
    logic          w_frame_end;
    logic [3:0]    w_hits;
    logic [15:0]   w_frame;
    logic [1:0]    w_bits;
    logic [3:0]    w_idx;
    logic [5:0]    w_res;
    logic [3:0]    w_next_cnt;
    logic          w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= keyboard_col;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_tick      = (r_dwell == DWELL_LAST);
    assign w_frame_end = w_tick && (r_row_idx == 2'd3);
    assign w_hits      = ~r_col_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell   <= '0;
            r_row_idx <= '0;
        end else if (w_tick) begin
            r_dwell   <= '0;
            r_row_idx <= r_row_idx + 2'd1;
        end else begin
            r_dwell   <= r_dwell + CW'(1);
        end
    end

    // Row 3 is never stored: it is classified straight from the live sample
    // on the frame-end tick, so rows 0-2 are the only snapshot state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_tick) begin
            case (r_row_idx)
                2'd0:    r_snap[3:0]  <= w_hits;
                2'd1:    r_snap[7:4]  <= w_hits;
                2'd2:    r_snap[11:8] <= w_hits;
                default: ;
            endcase
        end
    end

    assign w_frame = {w_hits, r_snap};

    always_comb begin
        w_bits = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                if (w_bits != 2'd2)
                    w_bits = w_bits + 2'd1;
                w_idx = 4'(i);
            end
        end
        case (w_bits)
            2'd0:    w_res = {RES_NONE, 4'd0};
            2'd1:    w_res = {RES_SINGLE, w_idx};
            default: w_res = {RES_MULTI, 4'd0};
        endcase
    end

    always_comb begin
        w_next_cnt = 4'd1;
        if (w_res == r_prev_res)
            w_next_cnt = (r_stable_cnt >= DEB_MAX) ? DEB_MAX : r_stable_cnt + 4'd1;
    end

    assign w_accept = w_frame_end && (w_next_cnt == DEB_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_res   <= {RES_NONE, 4'd0};
            r_stable_cnt <= '0;
        end else if (w_frame_end) begin
            r_prev_res   <= w_res;
            r_stable_cnt <= w_next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_res   <= {RES_NONE, 4'd0};
            r_state     <= S_IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_accept) begin
                r_acc_res <= w_res;
                case (r_state)
                    S_IDLE: begin
                        if (w_res[5:4] == RES_SINGLE) begin
                            r_key_code  <= w_res[3:0];
                            r_key_valid <= 1'b1;
                            r_key_down  <= 1'b1;
                            r_state     <= S_DOWN;
                        end
                    end
                    default: begin
                        if (w_res[5:4] == RES_NONE) begin
                            r_key_down <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign keyboard_row = ~(4'b0001 << r_row_idx);
    assign key_code     = r_key_code;
    assign key_valid    = r_key_valid;
    assign key_down     = r_key_down;
    assign key_multi    = (r_acc_res[5:4] == RES_MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  keyboard_row;
    logic [3:0]  keyboard_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic        key_multi;
    logic [15:0] keys;

    int n_checks;
    int n_fail;
    int pulse_cnt;
    int cyc;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_down     (key_down),
        .key_multi    (key_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        keyboard_col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!keyboard_row[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c])
                        keyboard_col[c] = 1'b0;
    end

    always @(negedge clk)
        if (key_valid === 1'b1)
            pulse_cnt <= pulse_cnt + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sel 0: key_valid high, 1: key_down low, 2: key_multi high. cyc = -1 on timeout.
    task automatic wait_for(input int sel, input int max_cyc, output int cyc_o);
        cyc_o = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && key_valid === 1'b1) ||
                (sel == 1 && key_down  === 1'b0) ||
                (sel == 2 && key_multi === 1'b1)) begin
                cyc_o = n;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_row"},   keyboard_row, 4'b1110);
        chk_eq({tag, "_code"},  key_code,     4'd0);
        chk_eq({tag, "_valid"}, key_valid,    1'b0);
        chk_eq({tag, "_down"},  key_down,     1'b0);
        chk_eq({tag, "_multi"}, key_multi,    1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        keys      = 16'h0200;

        // reset, row walk, and key 9 held from reset release
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_row;
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk_eq("row_walk", keyboard_row, exp_row);
        end
        wait_for(0, 64, cyc);
        chk_eq("k9_latency", cyc, 32);
        chk_eq("k9_code", key_code, 4'd9);
        chk_eq("k9_down", key_down, 1'b1);
        chk_eq("k9_multi", key_multi, 1'b0);
        keys = 16'h0000;
        @(posedge clk);
        #1;
        chk_eq("k9_one_cycle", key_valid, 1'b0);
        wait_for(1, 80, cyc);
        chk_eq("k9_release", cyc, 47);
        chk_eq("k9_pulses", pulse_cnt, 1);

        // bounce on key 5: toggles every 20 cycles, then held
        for (int s = 0; s < 5; s++) begin
            keys = (s % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (20) @(posedge clk);
            #1;
        end
        keys = 16'h0020;
        chk_eq("bounce_nopulse", pulse_cnt, 1);
        wait_for(0, 60, cyc);
        chk_eq("bounce_latency", cyc, 28);
        chk_eq("bounce_code", key_code, 4'd5);
        keys = 16'h0000;
        wait_for(1, 80, cyc);
        chk_eq("k5_release", cyc, 48);

        // keys 0 and 15 together, then 15 released
        keys = 16'h8001;
        wait_for(2, 80, cyc);
        chk_eq("multi_latency", cyc, 48);
        chk_eq("multi_nopulse", pulse_cnt, 2);
        chk_eq("multi_down", key_down, 1'b0);
        keys = 16'h0001;
        wait_for(0, 80, cyc);
        chk_eq("k0_latency", cyc, 48);
        chk_eq("k0_code", key_code, 4'd0);
        chk_eq("k0_multi", key_multi, 1'b0);
        chk_eq("k0_down", key_down, 1'b1);
        keys = 16'h0000;
        wait_for(1, 80, cyc);
        chk_eq("k0_release", cyc, 48);

        // roll-over 3 -> 7 without release
        keys = 16'h0008;
        wait_for(0, 80, cyc);
        chk_eq("k3_latency", cyc, 48);
        chk_eq("k3_code", key_code, 4'd3);
        keys = 16'h0080;
        repeat (64) @(posedge clk);
        #1;
        chk_eq("roll_nopulse", pulse_cnt, 4);
        chk_eq("roll_code", key_code, 4'd3);
        chk_eq("roll_down", key_down, 1'b1);
        keys = 16'h0000;
        wait_for(1, 80, cyc);
        chk_eq("roll_release", cyc, 48);
        chk_eq("roll_release_pulses", pulse_cnt, 4);
        keys = 16'h0080;
        wait_for(0, 80, cyc);
        chk_eq("k7_latency", cyc, 48);
        chk_eq("k7_code", key_code, 4'd7);
        keys = 16'h0000;
        wait_for(1, 80, cyc);
        chk_eq("k7_release", cyc, 48);

        // reset while key 12 is held down
        keys = 16'h1000;
        wait_for(0, 80, cyc);
        chk_eq("k12_latency", cyc, 48);
        chk_eq("k12_code", key_code, 4'd12);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        wait_for(0, 80, cyc);
        chk_eq("k12_again_latency", cyc, 48);
        chk_eq("k12_again_code", key_code, 4'd12);
        chk_eq("k12_again_down", key_down, 1'b1);
        @(posedge clk);
        #1;
        chk_eq("final_valid", key_valid, 1'b0);
        chk_eq("final_pulses", pulse_cnt, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
